// File: rtl/snake_pkg.sv
// Shared definitions for the snake input controller: direction encoding,
// debounce FSM states and direction helpers.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_HI = 2'b01,
    PRESSED = 2'b10,
    WAIT_LO = 2'b11
  } deb_state_t;

  // Up/down and left/right differ only in bit 0 of the encoding.
  function automatic logic [1:0] opposite_dir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

  // Pulse vector is ordered {U,D,L,R}; U has highest priority.
  function automatic logic [1:0] pulse_to_dir(input logic [3:0] p);
    logic [1:0] d;
    if (p[3])      d = DIR_UP;
    else if (p[2]) d = DIR_DOWN;
    else if (p[1]) d = DIR_LEFT;
    else           d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchroniser, debounce FSM with a saturating
// stability counter, and a single-cycle pulse per accepted press.
module btn_debounce
  import snake_pkg::*;
#(
  parameter int DEB_CYCLES = 4_000_000,
  parameter int CNT_W      = 22
) (
  input  logic ClkPort,
  input  logic Reset,
  input  logic btn,
  output logic pulse
);

  localparam logic [CNT_W-1:0] DEB_VAL = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       sync_reg;
  logic             synced;
  deb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;

  assign synced = sync_reg[1];

  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      sync_reg  <= 2'b00;
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], btn};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Saturating increment keeps a stuck count from wrapping back to zero.
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (synced) state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (!synced) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_inc == DEB_VAL) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        state_next = WAIT_LO;
        cnt_next   = '0;
      end
      WAIT_LO: begin
        // A bounce back high restarts the release count.
        if (synced) begin
          cnt_next = '0;
        end else if (cnt_inc == DEB_VAL) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign pulse = (state_reg == PRESSED);

endmodule

// File: rtl/snake_input_ctrl.sv
// Snake direction input: four debounced buttons feed a pending-direction latch
// committed on move_tick. Define SNAKE_REVERSE_BLOCK_EN to discard 180-degree reversals.
module snake_input_ctrl
  import snake_pkg::*;
#(
  parameter int DEB_CYCLES = 4_000_000,
  parameter int CNT_W      = 22
) (
  input  logic       ClkPort,
  input  logic       Reset,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       move_tick,
  output logic [1:0] dir,
  output logic       moving,
  output logic [3:0] btn_pulse,
  output logic [1:0] pending
);

  logic [3:0] btn_raw;
  assign btn_raw = {BtnU, BtnD, BtnL, BtnR};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
      ) u_deb (
        .ClkPort(ClkPort),
        .Reset  (Reset),
        .btn    (btn_raw[gi]),
        .pulse  (btn_pulse[gi])
      );
    end
  endgenerate

  logic [1:0] dir_reg, dir_next;
  logic [1:0] pending_reg, pending_next;
  logic       pending_valid_reg, pending_valid_next;
  logic       moving_reg, moving_next;
  logic       any_pulse;
  logic [1:0] cand_dir;
  logic       cand_valid;
  logic       reverse;

  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      dir_reg           <= DIR_RIGHT;
      pending_reg       <= DIR_RIGHT;
      pending_valid_reg <= 1'b0;
      moving_reg        <= 1'b0;
    end else begin
      dir_reg           <= dir_next;
      pending_reg       <= pending_next;
      pending_valid_reg <= pending_valid_next;
      moving_reg        <= moving_next;
    end
  end

  // A pulse coinciding with move_tick bypasses the latch and commits directly.
  assign any_pulse  = |btn_pulse;
  assign cand_dir   = any_pulse ? pulse_to_dir(btn_pulse) : pending_reg;
  assign cand_valid = any_pulse | pending_valid_reg;

`ifdef SNAKE_REVERSE_BLOCK_EN
  assign reverse = moving_reg && (cand_dir == opposite_dir(dir_reg));
`else
  assign reverse = 1'b0;
`endif

  always_comb begin
    dir_next           = dir_reg;
    pending_next       = pending_reg;
    pending_valid_next = pending_valid_reg;
    moving_next        = moving_reg;
    if (any_pulse) begin
      pending_next       = cand_dir;
      pending_valid_next = 1'b1;
    end
    if (move_tick) begin
      pending_valid_next = 1'b0;
      if (cand_valid && !reverse) begin
        dir_next    = cand_dir;
        moving_next = 1'b1;
      end
    end
  end

  assign dir     = dir_reg;
  assign moving  = moving_reg;
  assign pending = pending_reg;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Self-checking bench for snake_input_ctrl: directed scenarios plus random
// bouncing buttons compared cycle by cycle against a run-length reference model.
module tb_snake_input_ctrl;

  localparam int D = 8;

  logic       ClkPort = 1'b0;
  logic       Reset   = 1'b1;
  logic       BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0;
  logic       move_tick = 1'b0;
  logic [1:0] dir;
  logic       moving;
  logic [3:0] btn_pulse;
  logic [1:0] pending;

  always #5 ClkPort = ~ClkPort;

  snake_input_ctrl #(.DEB_CYCLES(D), .CNT_W(4)) dut (
    .ClkPort  (ClkPort),
    .Reset    (Reset),
    .BtnU     (BtnU),
    .BtnD     (BtnD),
    .BtnL     (BtnL),
    .BtnR     (BtnR),
    .move_tick(move_tick),
    .dir      (dir),
    .moving   (moving),
    .btn_pulse(btn_pulse),
    .pending  (pending)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, bit i of each vector follows {U,D,L,R}.
  logic       h1 [4];
  logic       h2 [4];
  bit         armed [4];
  bit         just_p [4];
  int         hi_run [4];
  int         lo_run [4];
  logic [3:0] m_pulse;
  logic [1:0] m_dir, m_pend;
  bit         m_pv, m_mov;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      h1[i] = 1'b0; h2[i] = 1'b0;
      armed[i] = 1'b1; just_p[i] = 1'b0;
      hi_run[i] = 0; lo_run[i] = 0;
    end
    m_pulse = 4'b0000;
    m_dir = 2'b11; m_pend = 2'b11;
    m_pv = 1'b0; m_mov = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] b, input bit t);
    logic [1:0] c;
    bit         cv, blk;
    logic [3:0] np;
    logic       s;
    if (m_pulse[3])      c = 2'd0;
    else if (m_pulse[2]) c = 2'd1;
    else if (m_pulse[1]) c = 2'd2;
    else if (m_pulse[0]) c = 2'd3;
    else                 c = m_pend;
    cv  = (m_pulse != 4'b0000) || m_pv;
    blk = 1'b0;
`ifdef SNAKE_REVERSE_BLOCK_EN
    // Opposites share the axis (value/2) but differ in direction.
    blk = m_mov && (c[1] == m_dir[1]) && (c != m_dir);
`endif
    if (m_pulse != 4'b0000) begin
      m_pend = c;
      m_pv   = 1'b1;
    end
    if (t) begin
      m_pv = 1'b0;
      if (cv && !blk) begin
        m_dir = c;
        m_mov = 1'b1;
      end
    end
    // Press accepted after D+1 consecutive synced-high samples while armed;
    // re-armed after D consecutive synced-low samples following the pulse.
    np = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      s = h2[i];
      h2[i] = h1[i];
      h1[i] = b[i];
      if (just_p[i]) begin
        just_p[i] = 1'b0;
        lo_run[i] = 0;
      end else if (!armed[i]) begin
        lo_run[i] = s ? 0 : lo_run[i] + 1;
        if (lo_run[i] == D) begin
          armed[i]  = 1'b1;
          hi_run[i] = 0;
        end
      end else begin
        hi_run[i] = s ? hi_run[i] + 1 : 0;
        if (hi_run[i] == D + 1) begin
          np[i]     = 1'b1;
          just_p[i] = 1'b1;
          armed[i]  = 1'b0;
          lo_run[i] = 0;
        end
      end
    end
    m_pulse = np;
  endtask

  task automatic step(input logic [3:0] b, input bit t, input bit r);
    {BtnU, BtnD, BtnL, BtnR} = b;
    move_tick = t;
    Reset     = r;
    @(posedge ClkPort);
    if (r) model_reset();
    else   model_edge(b, t);
    #1;
    check("pulse",   {4'h0, btn_pulse}, {4'h0, m_pulse});
    check("dir",     {6'h0, dir},       {6'h0, m_dir});
    check("moving",  {7'h0, moving},    {7'h0, m_mov});
    check("pending", {6'h0, pending},   {6'h0, m_pend});
  endtask

  task automatic press(input logic [3:0] b, input int hold, input int rel, output int npulse);
    npulse = 0;
    for (int k = 0; k < hold + rel; k++) begin
      step((k < hold) ? b : 4'b0000, 1'b0, 1'b0);
      if (btn_pulse != 4'b0000) npulse++;
    end
  endtask

  initial begin
    int np, nr, first;
    logic [3:0] raw;
    model_reset();
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);

    // Idle after reset
    np = 0;
    repeat (50) begin
      step(4'b0000, 1'b0, 1'b0);
      if (btn_pulse != 4'b0000) np++;
    end
    check("idle_pulses", 8'(np), 8'd0);
    check("idle_moving", {7'h0, moving}, 8'd0);
    check("idle_dir", {6'h0, dir}, 8'h3);

    // BtnR with three 2-cycle bounces in the first 10 cycles
    np = 0; nr = 0;
    for (int k = 0; k < 50; k++) begin
      raw = (k < 30 && !(k inside {1, 2, 4, 5, 7, 8})) ? 4'b0001 : 4'b0000;
      step(raw, 1'b0, 1'b0);
      if (btn_pulse != 4'b0000) np++;
      if (btn_pulse == 4'b0001) nr++;
    end
    check("bounce_any_pulses", 8'(np), 8'd1);
    check("bounce_r_pulses", 8'(nr), 8'd1);

    step(4'b0000, 1'b1, 1'b0);
    check("first_commit_dir", {6'h0, dir}, 8'h3);
    check("first_commit_moving", {7'h0, moving}, 8'd1);

    // Last press before a tick wins; idle tick holds
    press(4'b1000, 12, 14, np);
    check("u_pulses", 8'(np), 8'd1);
    press(4'b0010, 12, 14, np);
    step(4'b0000, 1'b1, 1'b0);
    check("last_wins_dir", {6'h0, dir}, 8'h2);
    step(4'b0000, 1'b1, 1'b0);
    check("idle_tick_dir", {6'h0, dir}, 8'h2);

    // U and D together: U has priority
    press(4'b1100, 12, 14, np);
    step(4'b0000, 1'b1, 1'b0);
    check("ud_priority_dir", {6'h0, dir}, 8'h0);

    // Reversal right -> left
    press(4'b0001, 12, 14, np);
    step(4'b0000, 1'b1, 1'b0);
    check("setup_right_dir", {6'h0, dir}, 8'h3);
    press(4'b0010, 12, 14, np);
    step(4'b0000, 1'b1, 1'b0);
`ifdef SNAKE_REVERSE_BLOCK_EN
    check("reverse_dir", {6'h0, dir}, 8'h3);
`else
    check("reverse_dir", {6'h0, dir}, 8'h2);
`endif

    // Reset at debounce count 5 while BtnD is held
    np = 0;
    for (int k = 0; k < 8; k++) begin
      step(4'b0100, 1'b0, 1'b0);
      if (btn_pulse != 4'b0000) np++;
    end
    step(4'b0100, 1'b0, 1'b1);
    first = -1;
    for (int k = 1; k <= 16; k++) begin
      step(4'b0100, 1'b0, 1'b0);
      if (btn_pulse != 4'b0000) begin
        np++;
        if (first < 0) first = k;
      end
    end
    check("reset_abort_pulses", 8'(np), 8'd1);
    check("reset_abort_latency", 8'(first), 8'd11);
    press(4'b0000, 0, 14, np);

    // Random bouncing buttons, ticks and occasional resets
    raw = 4'b0000;
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(23) == 0) raw[i] = ~raw[i];
      step(raw, ($urandom_range(11) == 0), ($urandom_range(699) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
